// File: rtl/bin2bcd_pkg.sv
// ----------------------------------------------------------------------------
// bin2bcd_pkg
// Shared definitions for the sequential binary-to-BCD converter:
//   WIDTH_DEF / DIGITS_DEF : default binary width and BCD digit count
//   cnt_width()            : width of the shift-cycle counter for a given WIDTH
//   CNT_W_DEF              : counter width for the default WIDTH
//   NDIG_W                 : width of the significant-digit count output
//   state_e                : converter FSM states
// ----------------------------------------------------------------------------
package bin2bcd_pkg;

  localparam int unsigned WIDTH_DEF  = 64;
  localparam int unsigned DIGITS_DEF = 20;
  localparam int unsigned NDIG_W     = 5;

  // The counter runs 0..w-1, so it needs clog2(w) bits (at least one).
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int unsigned CNT_W_DEF = cnt_width(WIDTH_DEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage : bin2bcd_pkg

// File: rtl/bcd_digit_adj.sv
// ----------------------------------------------------------------------------
// bcd_digit_adj
// Double-dabble correction for one BCD digit: a digit of 5 or more gets 3
// added so that the following left shift carries correctly into the next
// decimal digit.
//   digit_i : current BCD digit (0..9 in normal operation)
//   digit_o : corrected digit, ready to be shifted
// ----------------------------------------------------------------------------
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  // Add-3 correction, shift/add only.
  always_comb begin
    digit_o = digit_i;
    if (digit_i >= 4'd5) begin
      digit_o = digit_i + 4'd3;
    end else begin
      digit_o = digit_i;
    end
  end

endmodule : bcd_digit_adj

// File: rtl/bin2bcd_seq.sv
// ----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential (one bit per cycle) double-dabble binary-to-BCD converter with
// valid/ready handshakes on both sides.
//   clk         : clock, rising edge
//   rst_n       : asynchronous active-low reset
//   in_valid    : in_bin holds a value to convert
//   in_ready    : converter idle and able to accept a value
//   in_bin      : unsigned binary value, WIDTH bits
//   out_valid   : out_bcd / out_ndigits hold a finished result
//   out_ready   : consumer takes the result
//   out_bcd     : packed BCD, digit 0 (units) in bits [3:0]
//   out_ndigits : number of significant decimal digits (1 for value 0)
//
// Timing: the accepting edge loads the value, WIDTH edges perform the shifts,
// and one further edge registers the result and its digit count, so
// out_valid rises WIDTH+1 edges after acceptance.
// ----------------------------------------------------------------------------
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned DIGITS = DIGITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic [NDIG_W-1:0]     out_ndigits
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);
  localparam int unsigned BCD_W = 4 * DIGITS;

  state_e                   state_q;
  logic [WIDTH-1:0]         bin_q;
  logic [WIDTH-1:0]         bin_d;
  logic [BCD_W-1:0]         bcd_q;
  logic [BCD_W-1:0]         bcd_d;
  logic [BCD_W-1:0]         adj_s;
  logic [BCD_W+WIDTH-1:0]   shifted_s;
  logic [CNT_W-1:0]         cnt_q;
  logic                     in_ready_q;
  logic                     out_valid_q;
  logic [BCD_W-1:0]         out_bcd_q;
  logic [NDIG_W-1:0]        out_ndig_q;
  logic [NDIG_W-1:0]        ndig_s;

  // Index of the most significant nonzero digit plus one; 1 for an all-zero value.
  function automatic logic [NDIG_W-1:0] count_digits(input logic [BCD_W-1:0] bcd);
    logic [NDIG_W-1:0] n;
    n = NDIG_W'(1);
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd[4*i +: 4] != 4'd0) begin
        n = NDIG_W'(i + 1);
      end
    end
    return n;
  endfunction

  // One correction cell per BCD digit.
  for (genvar g = 0; g < int'(DIGITS); g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (bcd_q[4*g +: 4]),
      .digit_o (adj_s[4*g +: 4])
    );
  end

  // {bcd,bin} shifted left one place: the binary MSB enters digit 0 LSB.
  // The bit shifted out of the top digit is always zero when DIGITS is
  // large enough for WIDTH.
  assign shifted_s = {adj_s, bin_q} << 1'b1;
  assign bcd_d     = shifted_s[WIDTH +: BCD_W];
  assign bin_d     = shifted_s[WIDTH-1:0];
  assign ndig_s    = count_digits(bcd_q);

  // Converter FSM with all datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bin_q       <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_bcd_q   <= '0;
      out_ndig_q  <= NDIG_W'(1);
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            bin_q      <= in_bin;
            bcd_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          bin_q <= bin_d;
          bcd_q <= bcd_d;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            cnt_q   <= '0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          // First DONE cycle latches the result; afterwards it is held
          // until the consumer takes it.
          if (!out_valid_q) begin
            out_bcd_q   <= bcd_q;
            out_ndig_q  <= ndig_s;
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          cnt_q       <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_bcd     = out_bcd_q;
  assign out_ndigits = out_ndig_q;

endmodule : bin2bcd_seq

// File: tb/tb_bin2bcd_seq.sv
// ----------------------------------------------------------------------------
// tb_bin2bcd_seq
// Directed self-checking bench for bin2bcd_seq with hand-computed BCD results.
// ----------------------------------------------------------------------------
module tb_bin2bcd_seq;

  localparam int unsigned WIDTH  = 64;
  localparam int unsigned DIGITS = 20;

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_bin;
  logic                 out_valid;
  logic                 out_ready;
  logic [4*DIGITS-1:0]  out_bcd;
  logic [4:0]           out_ndigits;

  int n_checks;
  int n_fail;

  bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_bin      (in_bin),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_bcd     (out_bcd),
    .out_ndigits (out_ndigits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present v for one edge (converter must be idle) and wait for out_valid.
  task automatic start_and_wait(input logic [WIDTH-1:0] v, output int lat);
    in_valid = 1'b1;
    in_bin   = v;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_eq("in_ready_low_after_accept", {127'd0, in_ready}, 128'd0);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  // Full conversion with result check and handshake completion.
  task automatic convert(input string tag, input logic [WIDTH-1:0] v,
                         input logic [79:0] exp_bcd, input logic [4:0] exp_nd);
    int lat;
    start_and_wait(v, lat);
    check_eq({tag, "_latency"}, 128'(lat), 128'd65);
    check_eq({tag, "_valid"}, {127'd0, out_valid}, 128'd1);
    check_eq({tag, "_bcd"}, {48'd0, out_bcd}, {48'd0, exp_bcd});
    check_eq({tag, "_ndigits"}, {123'd0, out_ndigits}, {123'd0, exp_nd});
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq({tag, "_valid_drop"}, {127'd0, out_valid}, 128'd0);
    check_eq({tag, "_ready_back"}, {127'd0, in_ready}, 128'd1);
  endtask

  initial begin
    int lat;
    logic [79:0] held_bcd;
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_bin    = '0;
    out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", {127'd0, out_valid}, 128'd0);
    check_eq("rst_in_ready", {127'd0, in_ready}, 128'd1);
    check_eq("rst_out_bcd", {48'd0, out_bcd}, 128'd0);
    check_eq("rst_ndigits", {123'd0, out_ndigits}, 128'd1);
    rst_n = 1'b1;

    // First edge after release accepts
    convert("zero", 64'd0, 80'h0, 5'd1);
    convert("five_fact", 64'd120, 80'h120, 5'd3);
    convert("nine", 64'd9, 80'h9, 5'd1);
    convert("ten", 64'd10, 80'h10, 5'd2);
    convert("n99999", 64'd99999, 80'h99999, 5'd5);
    convert("million", 64'd1000000, 80'h1000000, 5'd7);
    convert("twenty_fact", 64'd2432902008176640000, 80'h2432902008176640000, 5'd19);

    // All ones: widest value, every digit must stay decimal
    start_and_wait(64'hFFFF_FFFF_FFFF_FFFF, lat);
    check_eq("ones_latency", 128'(lat), 128'd65);
    check_eq("ones_bcd", {48'd0, out_bcd}, {48'd0, 80'h18446744073709551615});
    check_eq("ones_ndigits", {123'd0, out_ndigits}, 128'd20);
    for (int d = 0; d < int'(DIGITS); d++) begin
      check_eq("ones_digit_decimal", {127'd0, (out_bcd[4*d +: 4] <= 4'd9)}, 128'd1);
    end

    // Backpressure: hold 10 cycles while a second value is offered
    held_bcd = 80'h18446744073709551615;
    in_valid = 1'b1;
    in_bin   = 64'd5;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check_eq("bp_valid_held", {127'd0, out_valid}, 128'd1);
      check_eq("bp_in_ready_low", {127'd0, in_ready}, 128'd0);
      check_eq("bp_bcd_stable", {48'd0, out_bcd}, {48'd0, held_bcd});
      check_eq("bp_ndigits_stable", {123'd0, out_ndigits}, 128'd20);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq("bp_valid_drop", {127'd0, out_valid}, 128'd0);
    check_eq("bp_ready_back", {127'd0, in_ready}, 128'd1);
    // Nothing was captured during DONE: converter stays idle
    repeat (3) @(posedge clk);
    #1;
    check_eq("bp_no_capture", {127'd0, in_ready}, 128'd1);
    check_eq("bp_no_result", {127'd0, out_valid}, 128'd0);

    // Reset abort during SHIFT (cycle 30)
    in_valid = 1'b1;
    in_bin   = 64'd123456;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("abort_valid_low", {127'd0, out_valid}, 128'd0);
    check_eq("abort_in_ready", {127'd0, in_ready}, 128'd1);
    check_eq("abort_bcd_cleared", {48'd0, out_bcd}, 128'd0);
    check_eq("abort_ndigits", {123'd0, out_ndigits}, 128'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_eq("abort_ready_after_release", {127'd0, in_ready}, 128'd1);
    begin
      int stale;
      stale = 0;
      repeat (70) begin
        @(posedge clk);
        #1;
        if (out_valid) stale++;
      end
      check_eq("abort_no_stale", 128'(stale), 128'd0);
    end
    convert("four_fact", 64'd24, 80'h24, 5'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_bin2bcd_seq

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 64, binary input width (matches the 64-bit factorial result).
REQ-002 SHALL have parameter DIGITS, default 20, number of BCD output digits (ceil(WIDTH*log10(2))).
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, in_bin holds a value to convert.
REQ-006 SHALL have port in_ready, output, 1, block can accept a value.
REQ-007 SHALL have port in_bin, input, WIDTH, unsigned binary value, e.g. factorial output.
REQ-008 SHALL have port out_valid, output, 1, out_bcd/out_ndigits are valid.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-010 SHALL have port out_bcd, output, 4*DIGITS, packed BCD; digit 0 (units) in bits [3:0].
REQ-011 SHALL have port out_ndigits, output, 5, count of significant decimal digits, 1..DIGITS.

Function
REQ-012 SHALL implement an FSM with states IDLE, SHIFT, DONE.
REQ-013 IDLE: in_ready=1, out_valid=0; on in_valid&&in_ready SHALL capture in_bin, clear BCD accumulator, clear bit counter, go to SHIFT.
REQ-014 SHIFT: each cycle SHALL add 3 to every BCD digit >=5, then shift {bcd,bin} left one bit, shifting bin MSB into digit 0 LSB.
REQ-015 SHIFT SHALL last exactly WIDTH cycles (counter 0..WIDTH-1), then go to DONE.
REQ-016 Latency: out_valid SHALL rise exactly WIDTH+1 rising edges after the accepting edge (64+1 = 65 for defaults).
REQ-017 DONE: out_valid=1; out_bcd and out_ndigits SHALL hold stable while out_ready=0.
REQ-018 DONE with out_ready=1 SHALL transfer on that edge and return to IDLE; in_ready rises the following cycle (no same-cycle accept).
REQ-019 in_ready SHALL be 0 in SHIFT and DONE; in_valid in those states SHALL be ignored and no data captured.
REQ-020 out_ndigits SHALL equal index of most-significant nonzero digit +1; for value 0 SHALL be 1.
REQ-021 out_bcd and out_ndigits SHALL be registered outputs, not combinational from in_bin.
REQ-022 Every digit of out_bcd SHALL be in range 0..9 for any WIDTH-bit input, including all-ones.
REQ-023 out_bcd/out_ndigits content outside DONE SHALL be don't-care for consumers but SHALL not glitch X after reset.

Reset
REQ-024 rst_n low SHALL asynchronously force state IDLE, in_ready=1 after release, out_valid=0, out_bcd=0, out_ndigits=1, counter=0.
REQ-025 Reset asserted in SHIFT or DONE SHALL abort the conversion; no result is ever presented for the aborted input.
REQ-026 First acceptance after rst_n release SHALL be possible on the first rising edge with in_valid=1.

Structure
REQ-027 Shared package bin2bcd_pkg SHALL hold WIDTH/DIGITS defaults, counter width constant, and the state enum typedef.
REQ-028 One sub-module bcd_digit_adj SHALL implement the per-digit add-3-if->=5 correction, instantiated DIGITS times.
REQ-029 No multipliers or dividers SHALL be used; shift/add only.

Verification
REQ-030 in_bin=0 -> after 65 cycles out_bcd=0, out_ndigits=1.
REQ-031 in_bin=120 (5!) -> out_bcd digits "120" (low 12 bits 0x120, rest 0), out_ndigits=3.
REQ-032 in_bin=2432902008176640000 (20!) -> out_bcd = decimal 2432902008176640000, out_ndigits=19.
REQ-033 in_bin=0xFFFF_FFFF_FFFF_FFFF -> out_bcd = 18446744073709551615, out_ndigits=20, all digits <=9.
REQ-034 Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid stays 1, outputs stable, in_ready=0, second in_valid not captured.
REQ-035 rst_n pulsed low on SHIFT cycle 30 -> out_valid=0 immediately, in_ready=1 after release, no stale result; next input 24 (4!) converts to "24", ndigits 2.
